fwd_hazard_scoreboard: RTL and testbench

Parametrised forwarding and load-use hazard unit for the in-order integer pipeline. It tracks every in-flight writer from EX through the last writeback-capable stage, drives per-source forwarding selects for the instruction in EX, and raises a stall for the instruction in ID when a needed result will not be ready in time. It also inserts bubbles, honours flush and global hold, and keeps a stall-cycle counter. It sits beside the ID/EX pipeline registers and feeds the EX operand muxes.

---
 rtl/fwd_hazard_scoreboard_pkg.sv | 28 ++
 rtl/fwd_hazard_scoreboard_match.sv | 37 +++
 rtl/fwd_hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the forwarding / load-use hazard unit.
//   slot_t        : one tracked in-flight writer {valid, rd, we, rdy}
//   FWD_REGFILE   : forwarding select value meaning "take the register file"
//   STG_EX/STG_MEM: slot indices of the EX and MEM stages
//   live_writer() : true when a slot will really write a non-x0 register
// Slot fields are sized for the largest supported configuration; narrower
// instances zero-extend into them.
package fwd_hazard_scoreboard_pkg;

  localparam int RW_MAX      = 8;  // widest supported register index
  localparam int SLW_MAX     = 4;  // widest supported stage index / rdy field
  localparam int FWD_REGFILE = 0;
  localparam int STG_EX      = 1;
  localparam int STG_MEM     = 2;

  typedef struct packed {
    logic               valid;
    logic [RW_MAX-1:0]  rd;
    logic               we;
    logic [SLW_MAX-1:0] rdy;  // last stage whose end produces the result
  } slot_t;

  // x0 is hard-wired to zero, so a write to it is never a dependency.
  function automatic logic live_writer(input slot_t s);
    return s.valid && s.we && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_match.sv
// Youngest-writer search over a range of tracked slots.
//   src   : source register index being looked up
//   slots : all tracked slots, index 1 = EX (youngest) .. DEPTH = WB
//   hit   : some slot in K_LO..K_HI is a live writer of src
//   idx   : the smallest (youngest) matching slot index
//   rdy   : that slot's rdy field
module fwd_match
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int K_LO  = 1,
  parameter int K_HI  = 2
) (
  input  logic [RW-1:0]      src,
  input  slot_t              slots [1:DEPTH],
  output logic               hit,
  output logic [SLW_MAX-1:0] idx,
  output logic [SLW_MAX-1:0] rdy
);

  // Scan oldest to youngest so the youngest match is the last one written.
  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    rdy = '0;
    for (int k = K_HI; k >= K_LO; k--) begin
      if (live_writer(slots[k]) && (slots[k].rd == RW_MAX'(src))) begin
        hit = 1'b1;
        idx = SLW_MAX'(k);
        rdy = slots[k].rdy;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit for the in-order integer pipeline.
// Tracks in-flight writers from EX (slot 1) to WB (slot DEPTH), selects
// forwarding sources for the EX instruction and stalls ID when a needed
// result cannot be forwarded in time.
//   clk, rstn  : clock, asynchronous active-low reset
//   id_valid   : ID holds a real instruction
//   id_rs      : ID sources, source i at [i*RW +: RW]
//   id_rd/we   : ID destination and write enable
//   id_rdy     : last stage whose end produces the ID result (ALU 1, load 2)
//   hold       : global freeze
//   flush      : kill the ID instruction (branch resolved in EX)
//   stall      : ID must hold, IF/ID must not advance
//   ex_fwd     : per-source EX select, 0 = regfile, k-1 = slot k
//   stall_cnt  : saturating count of stall cycles
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter  int RW    = 5,
  parameter  int NSRC  = 2,
  parameter  int DEPTH = 3,
  parameter  int CNT_W = 16,
  localparam int SLW   = $clog2(DEPTH + 1),
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid,
  input  logic [NSRC*RW-1:0]    id_rs,
  input  logic [RW-1:0]         id_rd,
  input  logic                  id_we,
  input  logic [SLW-1:0]        id_rdy,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
  output logic [NSRC*SEL_W-1:0] ex_fwd,
  output logic [CNT_W-1:0]      stall_cnt
);

  slot_t              slots [1:DEPTH];
  logic [NSRC*RW-1:0] ex_rs;
  logic [CNT_W-1:0]   cnt_q;
  logic [NSRC-1:0]    src_not_ready;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic               f_hit, s_hit;
    logic [SLW_MAX-1:0] f_idx, f_rdy, s_idx, s_rdy;

    // Forward path: EX can only take results that sit in MEM or later.
    fwd_match #(.RW(RW), .DEPTH(DEPTH), .K_LO(STG_MEM), .K_HI(DEPTH)) u_fwd (
      .src   (ex_rs[gi*RW +: RW]),
      .slots (slots),
      .hit   (f_hit),
      .idx   (f_idx),
      .rdy   (f_rdy)
    );

    // A result produced at the end of stage rdy is forwardable from any later slot.
    assign ex_fwd[gi*SEL_W +: SEL_W] = (f_hit && (f_rdy < f_idx))
                                     ? SEL_W'(f_idx - SLW_MAX'(1))
                                     : SEL_W'(FWD_REGFILE);

    // Stall path: the ID consumer reaches EX one cycle from now, when the
    // writer now in slot k will be in slot k+1.
    fwd_match #(.RW(RW), .DEPTH(DEPTH), .K_LO(STG_EX), .K_HI(DEPTH-1)) u_stl (
      .src   (id_rs[gi*RW +: RW]),
      .slots (slots),
      .hit   (s_hit),
      .idx   (s_idx),
      .rdy   (s_rdy)
    );

    assign src_not_ready[gi] = s_hit && (s_rdy >= s_idx + SLW_MAX'(1));
  end

  assign stall     = id_valid && (|src_not_ready) && !flush && !hold;
  assign stall_cnt = cnt_q;

  // NOTE: the slot array is reset as well as the counter; an unreset valid
  // bit would fabricate hazards right after reset.
  // NOTE: sequential state uses non-blocking assignments so every slot shifts
  // from its pre-edge value regardless of loop order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= DEPTH; k++) slots[k] <= '0;
      ex_rs <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) slots[k] <= slots[k-1];
      if (flush || stall) begin
        slots[1] <= '0;  // bubble
        ex_rs    <= '0;
        // stall is already masked by flush, so a flush never counts.
        if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end else begin
        slots[1] <= '{valid: id_valid,
                      rd:    RW_MAX'(id_rd),
                      we:    id_we,
                      rdy:   SLW_MAX'(id_rdy)};
        ex_rs    <= id_valid ? id_rs : '0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed table-driven bench for fwd_hazard_scoreboard (DEPTH 3, CNT_W 4).
module tb_fwd_hazard_scoreboard;

  localparam int RW    = 5;
  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rstn;
  logic                id_valid;
  logic [NSRC*RW-1:0]  id_rs;
  logic [RW-1:0]       id_rd;
  logic                id_we;
  logic [1:0]          id_rdy;
  logic                hold;
  logic                flush;
  logic                stall;
  logic [3:0]          ex_fwd;
  logic [CNT_W-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(.RW(RW), .NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .id_rdy    (id_rdy),
    .hold      (hold),
    .flush     (flush),
    .stall     (stall),
    .ex_fwd    (ex_fwd),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs0, rs1, rd;
    logic       we;
    logic [1:0] rdy;
    logic       hold, flush;
    logic       e_stall;
    logic [3:0] e_fwd;   // {src1 sel, src0 sel}
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [4:0] rd, input logic we, input logic [1:0] rdy,
                     input logic h, input logic f, input logic es,
                     input logic [3:0] ef, input logic [3:0] ec);
    vec_t t;
    t.v = v; t.rs0 = rs0; t.rs1 = rs1; t.rd = rd; t.we = we; t.rdy = rdy;
    t.hold = h; t.flush = f; t.e_stall = es; t.e_fwd = ef; t.e_cnt = ec;
    tv.push_back(t);
  endtask

  task automatic idle(input logic [3:0] ef, input logic [3:0] ec);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, ef, ec);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic we, input logic [1:0] rdy,
                       input logic h, input logic f);
    id_valid = v;
    id_rs    = {rs1, rs0};
    id_rd    = rd;
    id_we    = we;
    id_rdy   = rdy;
    hold     = h;
    flush    = f;
  endtask

  initial begin
    int exp_cnt;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset stall", stall, 0);
    check("reset fwd", ex_fwd, 0);
    check("reset cnt", stall_cnt, 0);
    #10 rstn = 1'b1;

    //        v rs0 rs1 rd we rdy h f  stall fwd cnt
    idle(0, 0);                                     // 0
    add(1, 1, 2, 5, 1, 1, 0, 0, 0, 0, 0);           // 1  add x5
    add(1, 5, 5, 6, 1, 1, 0, 0, 0, 0, 0);           // 2  sub x6,x5,x5
    add(1, 5, 0, 9, 1, 1, 0, 0, 0, 4'h5, 0);        // 3  sub in EX: both from MEM
    idle(4'h2, 0);                                  // 4  third consumer: x5 from WB
    idle(0, 0);                                     // 5
    idle(0, 0);                                     // 6
    add(1, 1, 0, 7, 1, 2, 0, 0, 0, 0, 0);           // 7  lw x7
    add(1, 7, 0, 8, 1, 1, 0, 0, 1, 0, 0);           // 8  add x8,x7,x0 stalls
    add(1, 7, 0, 8, 1, 1, 0, 0, 0, 0, 1);           // 9  issues
    idle(4'h2, 1);                                  // 10 x7 from WB, src1 regfile
    idle(0, 1);                                     // 11
    idle(0, 1);                                     // 12
    add(1, 1, 2, 3, 1, 1, 0, 0, 0, 0, 1);           // 13 add x3
    add(1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 1);           // 14 addi x3
    add(1, 3, 3, 10, 1, 1, 0, 0, 0, 0, 1);          // 15 consumer of x3
    idle(4'h5, 1);                                  // 16 youngest (MEM) wins
    idle(0, 1);                                     // 17
    idle(0, 1);                                     // 18
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);           // 19 writer to x0
    add(1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1);           // 20 rd x4 but we=0
    add(1, 0, 4, 11, 1, 1, 0, 0, 0, 0, 1);          // 21 consumer of x0,x4
    idle(0, 1);                                     // 22 nothing live to forward
    idle(0, 1);                                     // 23
    idle(0, 1);                                     // 24
    add(1, 0, 0, 7, 1, 2, 0, 0, 0, 0, 1);           // 25 lw x7
    add(1, 7, 0, 8, 1, 1, 1, 0, 0, 0, 1);           // 26 hold
    add(1, 7, 0, 8, 1, 1, 1, 0, 0, 0, 1);           // 27 hold
    add(1, 7, 0, 8, 1, 1, 1, 0, 0, 0, 1);           // 28 hold
    add(1, 7, 0, 8, 1, 1, 0, 0, 1, 0, 1);           // 29 released: stall once
    add(1, 7, 0, 8, 1, 1, 0, 0, 0, 0, 2);           // 30 issues
    idle(4'h2, 2);                                  // 31
    idle(0, 2);                                     // 32
    idle(0, 2);                                     // 33
    add(1, 0, 0, 7, 1, 2, 0, 0, 0, 0, 2);           // 34 lw x7
    add(1, 7, 0, 8, 1, 1, 0, 1, 0, 0, 2);           // 35 flush over load-use
    idle(0, 2);                                     // 36 flush did not count
    add(1, 8, 8, 13, 1, 1, 0, 0, 0, 0, 2);          // 37 consumer of killed x8
    idle(0, 2);                                     // 38 no forward from killed op
    idle(0, 2);                                     // 39
    idle(0, 2);                                     // 40

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].rs0, tv[i].rs1, tv[i].rd, tv[i].we, tv[i].rdy,
            tv[i].hold, tv[i].flush);
      #1;
      check($sformatf("row%0d stall", i), stall, tv[i].e_stall);
      check($sformatf("row%0d fwd", i), ex_fwd, tv[i].e_fwd);
      check($sformatf("row%0d cnt", i), stall_cnt, tv[i].e_cnt);
    end

    // Saturation: a self-dependent load stalls every other cycle.
    exp_cnt = 2;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      drive(1, 7, 0, 7, 1, 2, 0, 0);
      #1;
      check($sformatf("sat%0d stall", i), stall, i % 2);
      check($sformatf("sat%0d cnt", i), stall_cnt, exp_cnt);
      if ((i % 2 == 1) && exp_cnt != 15) exp_cnt++;
    end
    @(negedge clk);
    #1;
    check("sat final stall", stall, 0);
    check("sat final cnt", stall_cnt, 15);

    // Asynchronous reset in the middle of a stall cycle.
    @(negedge clk);
    #1;
    check("pre-reset stall", stall, 1);
    #2 rstn = 1'b0;
    #1;
    check("async reset stall", stall, 0);
    check("async reset cnt", stall_cnt, 0);
    check("async reset fwd", ex_fwd, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post-reset stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
